// File: rtl/reg_abi_namer.sv
// RISC-V integer register index to packed-ASCII ABI name, one registered cycle.
// Define REG_ABI_NAMER_NAME_DECODE_EN to add the reverse (name to index) path.
module reg_abi_namer #(
    parameter int NAME_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              idx_valid,
    input  logic [IDX_W-1:0]  idx,
    output logic              name_valid,
    output logic [NAME_W-1:0] name,
    output logic              name_err
`ifdef REG_ABI_NAMER_NAME_DECODE_EN
    ,
    input  logic              name_in_valid,
    input  logic [NAME_W-1:0] name_in,
    output logic              idx_out_valid,
    output logic [4:0]        idx_out,
    output logic              idx_out_err
`endif
);

    localparam logic [NAME_W-1:0] NAME_INV = 32'h0069_6E76;
    localparam logic [NAME_W-1:0] NAME_FP  = 32'h0000_6670;

    // Names are right-justified: last character in the low byte, zero padding above.
    function automatic logic [NAME_W-1:0] abi_name(input logic [4:0] i);
        logic [NAME_W-1:0] n;
        n = '0;
        if (i == 5'd0)
            n = 32'h7A65_726F;
        else if (i == 5'd1)
            n = 32'h0000_7261;
        else if (i == 5'd2)
            n = 32'h0000_7370;
        else if (i == 5'd3)
            n = 32'h0000_6770;
        else if (i == 5'd4)
            n = 32'h0000_7470;
        else if (i <= 5'd7)
            n = {16'h0000, 8'h74, 8'h30 + {3'b000, i - 5'd5}};
        else if (i <= 5'd9)
            n = {16'h0000, 8'h73, 8'h30 + {3'b000, i - 5'd8}};
        else if (i <= 5'd17)
            n = {16'h0000, 8'h61, 8'h30 + {3'b000, i - 5'd10}};
        else if (i <= 5'd25)
            n = {16'h0000, 8'h73, 8'h30 + {3'b000, i - 5'd16}};
        else if (i <= 5'd27)
            n = {8'h00, 8'h73, 8'h31, 8'h30 + {3'b000, i - 5'd26}};
        else
            n = {16'h0000, 8'h74, 8'h30 + {3'b000, i - 5'd25}};
        return n;
    endfunction

    logic [NAME_W-1:0] fwd_name;
    logic              fwd_err;

    always_comb begin
        fwd_err  = idx[IDX_W-1];
        fwd_name = fwd_err ? NAME_INV : abi_name(idx[4:0]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            name_valid <= 1'b0;
            name       <= '0;
            name_err   <= 1'b0;
        end else begin
            name_valid <= idx_valid;
            if (idx_valid) begin
                name     <= fwd_name;
                name_err <= fwd_err;
            end
        end
    end

`ifdef REG_ABI_NAMER_NAME_DECODE_EN
    logic [4:0] dec_idx;
    logic       dec_hit;

    // Table names are unique, so match order does not matter; "fp" aliases s0.
    always_comb begin
        dec_idx = 5'd0;
        dec_hit = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (name_in == abi_name(5'(k))) begin
                dec_idx = 5'(k);
                dec_hit = 1'b1;
            end
        end
        if (name_in == NAME_FP) begin
            dec_idx = 5'd8;
            dec_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_out_valid <= 1'b0;
            idx_out       <= 5'd0;
            idx_out_err   <= 1'b0;
        end else begin
            idx_out_valid <= name_in_valid;
            if (name_in_valid) begin
                idx_out     <= dec_idx;
                idx_out_err <= ~dec_hit;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_abi_namer.sv
// Directed self-checking bench for reg_abi_namer (reverse path when REG_ABI_NAMER_NAME_DECODE_EN is set).
module tb_reg_abi_namer;

    logic        clk;
    logic        reset;
    logic        idx_valid;
    logic [5:0]  idx;
    logic        name_valid;
    logic [31:0] name;
    logic        name_err;
`ifdef REG_ABI_NAMER_NAME_DECODE_EN
    logic        name_in_valid;
    logic [31:0] name_in;
    logic        idx_out_valid;
    logic [4:0]  idx_out;
    logic        idx_out_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_name [32];

    reg_abi_namer #(.NAME_W(32), .IDX_W(6)) dut (
        .clk(clk),
        .reset(reset),
        .idx_valid(idx_valid),
        .idx(idx),
        .name_valid(name_valid),
        .name(name),
        .name_err(name_err)
`ifdef REG_ABI_NAMER_NAME_DECODE_EN
        ,
        .name_in_valid(name_in_valid),
        .name_in(name_in),
        .idx_out_valid(idx_out_valid),
        .idx_out(idx_out),
        .idx_out_err(idx_out_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_name[0]  = 32'h7A65726F; exp_name[1]  = 32'h00007261;
        exp_name[2]  = 32'h00007370; exp_name[3]  = 32'h00006770;
        exp_name[4]  = 32'h00007470; exp_name[5]  = 32'h00007430;
        exp_name[6]  = 32'h00007431; exp_name[7]  = 32'h00007432;
        exp_name[8]  = 32'h00007330; exp_name[9]  = 32'h00007331;
        exp_name[10] = 32'h00006130; exp_name[11] = 32'h00006131;
        exp_name[12] = 32'h00006132; exp_name[13] = 32'h00006133;
        exp_name[14] = 32'h00006134; exp_name[15] = 32'h00006135;
        exp_name[16] = 32'h00006136; exp_name[17] = 32'h00006137;
        exp_name[18] = 32'h00007332; exp_name[19] = 32'h00007333;
        exp_name[20] = 32'h00007334; exp_name[21] = 32'h00007335;
        exp_name[22] = 32'h00007336; exp_name[23] = 32'h00007337;
        exp_name[24] = 32'h00007338; exp_name[25] = 32'h00007339;
        exp_name[26] = 32'h00733130; exp_name[27] = 32'h00733131;
        exp_name[28] = 32'h00007433; exp_name[29] = 32'h00007434;
        exp_name[30] = 32'h00007435; exp_name[31] = 32'h00007436;

        reset     = 1'b0;
        idx_valid = 1'b0;
        idx       = 6'd0;
`ifdef REG_ABI_NAMER_NAME_DECODE_EN
        name_in_valid = 1'b0;
        name_in       = 32'h0;
`endif
        #1;
        check("rst_valid", {31'b0, name_valid}, 32'd0);
        check("rst_name", name, 32'h0);
        check("rst_err", {31'b0, name_err}, 32'd0);
`ifdef REG_ABI_NAMER_NAME_DECODE_EN
        check("rst_rvalid", {31'b0, idx_out_valid}, 32'd0);
        check("rst_idx_out", {27'b0, idx_out}, 32'd0);
        check("rst_rerr", {31'b0, idx_out_err}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // reset mid-stream
        idx_valid = 1'b1;
        idx       = 6'd3;
        tick();
        check("pre_rst_valid", {31'b0, name_valid}, 32'd1);
        check("pre_rst_name", name, 32'h00006770);
        idx = 6'd5;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, name_valid}, 32'd0);
        check("async_rst_name", name, 32'h0);
        tick();
        check("held_rst_valid", {31'b0, name_valid}, 32'd0);
        check("held_rst_name", name, 32'h0);
        @(negedge clk);
        reset     = 1'b1;
        idx_valid = 1'b0;
        tick();
        check("post_rst_idle_valid", {31'b0, name_valid}, 32'd0);
        check("post_rst_idle_name", name, 32'h0);
        idx_valid = 1'b1;
        idx       = 6'd4;
        tick();
        check("post_rst_valid", {31'b0, name_valid}, 32'd1);
        check("post_rst_name", name, 32'h00007470);

        // back-to-back sweep
        for (int i = 0; i < 32; i++) begin
            idx = 6'(i);
            tick();
            check($sformatf("sweep_name_%0d", i), name, exp_name[i]);
            check($sformatf("sweep_err_%0d", i), {31'b0, name_err}, 32'd0);
            check($sformatf("sweep_valid_%0d", i), {31'b0, name_valid}, 32'd1);
        end

        // out of range
        idx = 6'd40;
        tick();
        check("oor40_name", name, 32'h00696E76);
        check("oor40_err", {31'b0, name_err}, 32'd1);
        check("oor40_valid", {31'b0, name_valid}, 32'd1);
        idx = 6'd63;
        tick();
        check("oor63_name", name, 32'h00696E76);
        check("oor63_err", {31'b0, name_err}, 32'd1);
        idx = 6'd32;
        tick();
        check("oor32_err", {31'b0, name_err}, 32'd1);

        // hold after idle
        idx = 6'd2;
        tick();
        check("sp_name", name, 32'h00007370);
        check("sp_err_clear", {31'b0, name_err}, 32'd0);
        idx_valid = 1'b0;
        idx       = 6'd9;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("hold_valid_%0d", c), {31'b0, name_valid}, 32'd0);
            check($sformatf("hold_name_%0d", c), name, 32'h00007370);
        end

`ifdef REG_ABI_NAMER_NAME_DECODE_EN
        name_in_valid = 1'b1;
        name_in       = 32'h00006670;
        tick();
        check("dec_fp_valid", {31'b0, idx_out_valid}, 32'd1);
        check("dec_fp_idx", {27'b0, idx_out}, 32'd8);
        check("dec_fp_err", {31'b0, idx_out_err}, 32'd0);
        name_in = 32'h00007337;
        tick();
        check("dec_s7_idx", {27'b0, idx_out}, 32'd23);
        check("dec_s7_err", {31'b0, idx_out_err}, 32'd0);
        name_in   = 32'h00005241;
        idx_valid = 1'b1;
        idx       = 6'd5;
        tick();
        check("dec_RA_err", {31'b0, idx_out_err}, 32'd1);
        check("dec_RA_idx", {27'b0, idx_out}, 32'd0);
        check("dec_RA_fwd_name", name, 32'h00007430);
        check("dec_RA_fwd_valid", {31'b0, name_valid}, 32'd1);
        check("dec_RA_fwd_err", {31'b0, name_err}, 32'd0);
        idx_valid = 1'b0;
        name_in   = 32'h00733131;
        tick();
        check("dec_s11_idx", {27'b0, idx_out}, 32'd27);
        check("dec_s11_err", {31'b0, idx_out_err}, 32'd0);
        name_in = 32'h20007261;
        tick();
        check("dec_pad_err", {31'b0, idx_out_err}, 32'd1);
        check("dec_pad_idx", {27'b0, idx_out}, 32'd0);
        name_in = 32'h7A65726F;
        tick();
        check("dec_zero_idx", {27'b0, idx_out}, 32'd0);
        check("dec_zero_err", {31'b0, idx_out_err}, 32'd0);
        name_in_valid = 1'b0;
        tick();
        check("dec_idle_valid", {31'b0, idx_out_valid}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
